// File: rtl/gpr_commit_ctrl_pkg.sv
// Shared widths and the queued commit entry for the GPR write-port controller.
package gpr_commit_ctrl_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int GPR_ADDR_WIDTH = 5;
    localparam int DATA_HIGH_GPR  = WORD_WIDTH - 1;

    typedef struct packed {
        logic [GPR_ADDR_WIDTH-1:0] addr;
        logic [DATA_HIGH_GPR:0]    value;
    } cmt_entry_t;

endpackage

// File: rtl/gpr_commit_ctrl_fwd_match.sv
// Operand forward lookup: compares every live queue entry against one read address
// and returns the youngest (closest to tail) matching value.
module gpr_fwd_match #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]      i_addr [DEPTH],
    input  logic [WORD_WIDTH-1:0]      i_value [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   i_head,
    input  logic [$clog2(DEPTH):0]     i_count,
    input  logic [ADDR_WIDTH-1:0]      i_rs_addr,
    output logic                       o_hit,
    output logic [WORD_WIDTH-1:0]      o_value
);
    import gpr_commit_ctrl_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Walk entries oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        o_hit   = 1'b0;
        o_value = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < i_count) && (i_rs_addr != '0) &&
                (i_addr[i_head + PW'(k)] == i_rs_addr)) begin
                o_hit   = 1'b1;
                o_value = i_value[i_head + PW'(k)];
            end
        end
    end

endmodule

// File: rtl/gpr_commit_ctrl.sv
// GPR write-port controller: buffers up to two retirements per cycle, drains one
// write per cycle, slots in low-priority debug writes and forwards queued values.
module gpr_commit_ctrl #(
    parameter int DEPTH      = 4,
    parameter int WORD_WIDTH = gpr_commit_ctrl_pkg::WORD_WIDTH,
    parameter int ADDR_WIDTH = gpr_commit_ctrl_pkg::GPR_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmt0_valid,
    input  logic [ADDR_WIDTH-1:0]     cmt0_addr,
    input  logic [WORD_WIDTH-1:0]     cmt0_value,
    input  logic                      cmt1_valid,
    input  logic [ADDR_WIDTH-1:0]     cmt1_addr,
    input  logic [WORD_WIDTH-1:0]     cmt1_value,
    output logic                      cmt_ready,
    input  logic                      dbg_wr_valid,
    input  logic [ADDR_WIDTH-1:0]     dbg_wr_addr,
    input  logic [WORD_WIDTH-1:0]     dbg_wr_value,
    output logic                      dbg_wr_ready,
    output logic                      commit_en,
    output logic [ADDR_WIDTH-1:0]     commit_dst_addr,
    output logic [WORD_WIDTH-1:0]     commit_dst_value,
    input  logic [ADDR_WIDTH-1:0]     rs1_addr,
    input  logic [ADDR_WIDTH-1:0]     rs2_addr,
    output logic                      fwd_rs1_hit,
    output logic [WORD_WIDTH-1:0]     fwd_rs1_value,
    output logic                      fwd_rs2_hit,
    output logic [WORD_WIDTH-1:0]     fwd_rs2_value,
    output logic [$clog2(DEPTH):0]    occupancy
);
    import gpr_commit_ctrl_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]          r_count;
    logic [PW-1:0]          r_head;
    logic [PW-1:0]          r_tail;
    cmt_entry_t             r_mem [DEPTH];

    logic                   w_acc0;
    logic                   w_acc1;
    logic                   w_push0;
    logic                   w_push1;
    logic                   w_pop;
    logic [PW-1:0]          w_tail1;
    logic [CW-1:0]          w_count_next;
    logic [ADDR_WIDTH-1:0]  w_addr_q [DEPTH];
    logic [WORD_WIDTH-1:0]  w_value_q [DEPTH];

    // Readiness depends on registered count only, so it never waits on this cycle's pop.
    assign cmt_ready    = (r_count <= CW'(DEPTH - 2));
    assign occupancy    = r_count;
    assign w_acc0       = cmt_ready & cmt0_valid;
    assign w_acc1       = w_acc0 & cmt1_valid;
    assign w_push0      = w_acc0 & (cmt0_addr != '0);
    assign w_push1      = w_acc1 & (cmt1_addr != '0);
    assign w_pop        = (r_count != '0);
    assign w_tail1      = r_tail + PW'(w_push0);
    assign w_count_next = r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
    assign dbg_wr_ready = dbg_wr_valid & (r_count == '0) & ~cmt0_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= w_count_next;
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= w_tail1 + PW'(w_push1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push0) r_mem[r_tail]  <= '{addr: cmt0_addr, value: cmt0_value};
        if (w_push1) r_mem[w_tail1] <= '{addr: cmt1_addr, value: cmt1_value};
    end

    // Queued commits own the port; a granted debug write to x0 is swallowed.
    always_comb begin
        commit_en        = 1'b0;
        commit_dst_addr  = '0;
        commit_dst_value = '0;
        if (w_pop) begin
            commit_en        = 1'b1;
            commit_dst_addr  = r_mem[r_head].addr;
            commit_dst_value = r_mem[r_head].value;
        end else if (dbg_wr_ready && (dbg_wr_addr != '0)) begin
            commit_en        = 1'b1;
            commit_dst_addr  = dbg_wr_addr;
            commit_dst_value = dbg_wr_value;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_addr_q[i]  = r_mem[i].addr;
            w_value_q[i] = r_mem[i].value;
        end
    end

    gpr_fwd_match #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_fwd_rs1 (
        .i_addr    (w_addr_q),
        .i_value   (w_value_q),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_rs_addr (rs1_addr),
        .o_hit     (fwd_rs1_hit),
        .o_value   (fwd_rs1_value)
    );

    gpr_fwd_match #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_fwd_rs2 (
        .i_addr    (w_addr_q),
        .i_value   (w_value_q),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_rs_addr (rs2_addr),
        .o_hit     (fwd_rs2_hit),
        .o_value   (fwd_rs2_value)
    );

endmodule
